// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults, rounding/saturation helpers and twiddle generation
//  sat(v, w)        clamp v to the signed w-bit range
//  rnd_shift(v, sh) add half an LSB, then arithmetic shift right by sh
//  tw_val(k,n,tw,im) twiddle component for exp(-j*2*pi*k/n) in Q1.(tw-1)
package fft_pkg;
   localparam int DW_DEF = 12;
   localparam int TW_DEF = 12;
   function automatic longint sat(input longint v, input int w);
      longint hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
   function automatic longint rnd_shift(input longint v, input int sh);
      return (v + (64'sd1 <<< (sh - 1))) >>> sh;
   endfunction
   // +1.0 maps to 2^(tw-1)-1 so that it stays representable
   function automatic int tw_val(input int k, input int n, input int tw, input bit im);
      real s, v;
      s = 2.0 ** $itor(tw - 1) - 1.0;
      v = $itor(k) * 6.283185307179586 / $itor(n);
      v = im ? -$sin(v) * s : $cos(v) * s;
      return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction
endpackage

// File: rtl/twiddle_rom.sv
// twiddle_rom: registered twiddle lookup, table of N/2 entries built at elaboration
//  clk, rst_n  clock, asynchronous active-low reset
//  en          load a new lookup this cycle
//  index       twiddle index k
//  wr, wi      registered cos / -sin components, one cycle after index
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int TW = 12,
   parameter int N  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [$clog2(N)-2:0]   index,
   output logic signed [TW-1:0]   wr,
   output logic signed [TW-1:0]   wi
);
   logic signed [TW-1:0] tab_re [N/2];
   logic signed [TW-1:0] tab_im [N/2];
   for (genvar i = 0; i < N / 2; i++) begin : g_tab
      localparam int RE = tw_val(i, N, TW, 1'b0);
      localparam int IM = tw_val(i, N, TW, 1'b1);
      assign tab_re[i] = TW'(RE);
      assign tab_im[i] = TW'(IM);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         wi <= '0;
      end else if (en) begin
         wr <= tab_re[index];
         wi <= tab_im[index];
      end
endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: pipelined radix-2 DIT butterfly, X = A + W*B, Y = A - W*B
//  clk, rst_n             clock, asynchronous active-low reset
//  in_valid, in_ready     input handshake
//  a_re, a_im, b_re, b_im input operands (B is multiplied by W)
//  index, scale           twiddle index k, halve outputs with rounding
//  out_valid, out_ready   output handshake
//  x_re, x_im, y_re, y_im saturated results
//  ovf                    sticky saturation flag, cleared only by reset
module butterfly_pipe
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF,
   parameter int N  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [DW-1:0]  a_re,
   input  logic signed [DW-1:0]  a_im,
   input  logic signed [DW-1:0]  b_re,
   input  logic signed [DW-1:0]  b_im,
   input  logic [$clog2(N)-2:0]  index,
   input  logic                  scale,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [DW-1:0]  x_re,
   output logic signed [DW-1:0]  x_im,
   output logic signed [DW-1:0]  y_re,
   output logic signed [DW-1:0]  y_im,
   output logic                  ovf
);
   localparam int PW = DW + TW;
   logic adv;
   logic v1, v2, v3, v4, sc1, sc2, sc3, sc4;
   logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im, a2_re, a2_im, a3_re, a3_im;
   logic signed [TW-1:0] wr, wi;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [DW:0]   pr3, pi3;
   // s4/o/t/clip index: 0 = x_re, 1 = x_im, 2 = y_re, 3 = y_im
   logic signed [DW+1:0] s4 [4];
   logic signed [DW-1:0] o [4];
   longint               t [4];
   logic [3:0]           clip;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   twiddle_rom #(.TW(TW), .N(N)) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .index (index),
      .wr    (wr),
      .wi    (wi)
   );
   // Datapath registers carry no reset; only the valids qualify them.
   always_ff @(posedge clk)
      if (adv) begin
         a1_re <= a_re;
         a1_im <= a_im;
         b1_re <= b_re;
         b1_im <= b_im;
         sc1   <= scale;
         a2_re <= a1_re;
         a2_im <= a1_im;
         sc2   <= sc1;
         p_rr  <= PW'(b1_re) * PW'(wr);
         p_ii  <= PW'(b1_im) * PW'(wi);
         p_ri  <= PW'(b1_re) * PW'(wi);
         p_ir  <= PW'(b1_im) * PW'(wr);
         a3_re <= a2_re;
         a3_im <= a2_im;
         sc3   <= sc2;
         // |W*B| can exceed full scale by sqrt2, hence one extra bit
         pr3   <= (DW+1)'(rnd_shift(longint'(p_rr) - longint'(p_ii), TW - 1));
         pi3   <= (DW+1)'(rnd_shift(longint'(p_ri) + longint'(p_ir), TW - 1));
         sc4   <= sc3;
         s4[0] <= (DW+2)'(longint'(a3_re) + longint'(pr3));
         s4[1] <= (DW+2)'(longint'(a3_im) + longint'(pi3));
         s4[2] <= (DW+2)'(longint'(a3_re) - longint'(pr3));
         s4[3] <= (DW+2)'(longint'(a3_im) - longint'(pi3));
      end
   always_comb
      for (int i = 0; i < 4; i++) begin
         t[i]    = sc4 ? rnd_shift(longint'(s4[i]), 1) : longint'(s4[i]);
         o[i]    = DW'(sat(t[i], DW));
         clip[i] = sat(t[i], DW) != t[i];
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         v4        <= 1'b0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
         x_re      <= '0;
         x_im      <= '0;
         y_re      <= '0;
         y_im      <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         v4        <= v3;
         out_valid <= v4;
         if (v4) begin
            x_re <= o[0];
            x_im <= o[1];
            y_re <= o[2];
            y_im <= o[3];
            ovf  <= ovf | (|clip);
         end
      end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: scoreboard bench for butterfly_pipe (N=8, DW=TW=12)
module tb_butterfly_pipe;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, scale = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, ovf;
   logic signed [11:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic signed [11:0] x_re, x_im, y_re, y_im;
   logic [1:0] index = '0;
   typedef struct { int xr; int xi; int yr; int yi; } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   int wtab_re[4] = '{2047, 1447, 0, -1447};
   int wtab_im[4] = '{0, -1447, -2047, -1447};
   always #5 clk = ~clk;
   butterfly_pipe #(.DW(12), .TW(12), .N(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .index(index), .scale(scale),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im), .ovf(ovf)
   );
   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask
   function automatic int fsat(input int v);
      return v > 2047 ? 2047 : v < -2048 ? -2048 : v;
   endfunction
   function automatic exp_t model(input int ar, ai, br, bi, k, input bit sc);
      int pr, pi;
      int s[4];
      exp_t e;
      pr = (br * wtab_re[k] - bi * wtab_im[k] + 1024) >>> 11;
      pi = (br * wtab_im[k] + bi * wtab_re[k] + 1024) >>> 11;
      s[0] = ar + pr; s[1] = ai + pi; s[2] = ar - pr; s[3] = ai - pi;
      for (int i = 0; i < 4; i++) s[i] = fsat(sc ? (s[i] + 1) >>> 1 : s[i]);
      e.xr = s[0]; e.xi = s[1]; e.yr = s[2]; e.yi = s[3];
      return e;
   endfunction
   task automatic send(input int ar, ai, br, bi, k, input bit sc, input exp_t e, output int waits);
      bit acc;
      a_re = 12'(ar); a_im = 12'(ai); b_re = 12'(br); b_im = 12'(bi);
      index = 2'(k); scale = sc; in_valid = 1'b1; waits = 0;
      forever begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
         waits++;
         if (waits > 50) begin chk("send_timeout", waits, 0); break; end
      end
      if (acc) q.push_back(e);
      in_valid = 1'b0;
   endtask
   task automatic sendv(input int i, output int waits);
      int ar, ai, br, bi, k;
      bit sc;
      ar = (i % 8) * 250 - 900; ai = 700 - (i % 8) * 180;
      br = (i % 8) * 313 - 1100; bi = 900 - (i % 8) * 260;
      k = i % 4; sc = bit'(i % 2);
      send(ar, ai, br, bi, k, sc, model(ar, ai, br, bi, k, sc), waits);
   endtask
   task automatic lat_check(input string nm);
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid && n < 10);
      chk(nm, n, 4);
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("drain", q.size(), 0);
   endtask
   always @(negedge clk)
      if (rst_n && out_valid) begin
         if (q.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            chk("x_re", x_re, q[0].xr);
            chk("x_im", x_im, q[0].xi);
            chk("y_re", y_re, q[0].yr);
            chk("y_im", y_im, q[0].yi);
            if (out_ready) void'(q.pop_front());
         end
      end
   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
   initial begin
      int w, tot;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_x_re", x_re, 0);
      chk("rst_y_im", y_im, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(100, 0, 50, 0, 0, 0, '{150, 0, 50, 0}, w);
      lat_check("lat_identity");
      drain();
      chk("ovf_identity", ovf, 0);
      send(0, 0, 64, 0, 2, 0, '{0, -64, 0, 64}, w);
      drain();
      send(2047, 0, 2047, 0, 0, 0, '{2047, 0, 1, 0}, w);
      drain();
      chk("ovf_sat", ovf, 1);
      fork
         for (int i = 0; i < 8; i++) sendv(i, w);
         begin
            int n = 0;
            do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
            out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk); chk("stall_in_ready", in_ready, 0);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("ovf_sticky", ovf, 1);
      rst_n = 1'b0;
      #1;
      chk("ovf_cleared", ovf, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send(2047, 0, 2047, 0, 0, 1, '{2047, 0, 1, 0}, w);
      drain();
      chk("ovf_scaled", ovf, 0);
      for (int i = 0; i < 6; i++) begin
         sendv(i + 2, w);
         @(posedge clk); #1;
      end
      tot = 0;
      for (int i = 0; i < 12; i++) begin sendv(i + 3, w); tot += w; end
      chk("throughput_waits", tot, 0);
      drain();
      for (int i = 0; i < 4; i++) sendv(i, w);
      @(posedge clk); #1;
      chk("pre_reset_out_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_x_re", x_re, 0);
      q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      sendv(5, w);
      lat_check("lat_after_reset");
      drain();
      repeat (8) @(posedge clk);
      #1;
      chk("final_queue", q.size(), 0);
      chk("final_out_valid", out_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
